led_fader: RTL



---
 rtl/led_pkg.sv | 12 +
 rtl/led_fader_channel.sv | 57 +++++
 rtl/led_fader.sv | 60 ++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared LED constants used by the walker and the fader.
// Both blocks rely on the same channel count, PWM width and full-scale brightness.
package led_pkg;

    localparam int NLEDS_DEF        = 8;
    localparam int PWM_BITS_DEF     = 8;
    localparam int DECAY_PERIOD_DEF = 65536;
    localparam int DECAY_SHIFT_DEF  = 2;

    localparam logic [PWM_BITS_DEF-1:0] FULL_SCALE = '1;

endpackage

// File: rtl/led_fader_channel.sv
// One LED channel: brightness with geometric decay, a duty shadow updated only
// at the PWM period boundary, and the registered PWM compare.
module led_fader_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS    = PWM_BITS_DEF,
    parameter int DECAY_SHIFT = DECAY_SHIFT_DEF
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_sel,
    input  logic                i_decay_tick,
    input  logic                i_period_end,
    input  logic [PWM_BITS-1:0] i_pwm_ctr,
    output logic                o_pwm
);

    localparam logic [PWM_BITS-1:0] FULL = '1;
    localparam logic [PWM_BITS-1:0] ONE  = PWM_BITS'(1);

    logic [PWM_BITS-1:0] brightness_q, brightness_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [PWM_BITS-1:0] step;
    logic                pwm_q, pwm_d;

    always_comb begin
        step         = brightness_q >> DECAY_SHIFT;
        brightness_d = brightness_q;
        // Selection wins over a decay tick landing in the same cycle.
        if (i_sel) begin
            brightness_d = FULL;
        end else if (i_decay_tick && (brightness_q != '0)) begin
            if (step == '0) begin
                brightness_d = brightness_q - ONE;
            end else begin
                brightness_d = brightness_q - step;
            end
        end
        duty_d = i_period_end ? brightness_q : duty_q;
        pwm_d  = (duty_q == FULL) || (i_pwm_ctr < duty_q);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            brightness_q <= '0;
            duty_q       <= '0;
            pwm_q        <= 1'b0;
        end else begin
            brightness_q <= brightness_d;
            duty_q       <= duty_d;
            pwm_q        <= pwm_d;
        end
    end

    assign o_pwm = pwm_q;

endmodule

// File: rtl/led_fader.sv
// LED fader: full brightness while selected by the walker, then a geometric
// "comet trail" fade, rendered as glitch-free per-LED PWM.
module led_fader
    import led_pkg::*;
#(
    parameter int NLEDS        = NLEDS_DEF,
    parameter int PWM_BITS     = PWM_BITS_DEF,
    parameter int DECAY_PERIOD = DECAY_PERIOD_DEF,
    parameter int DECAY_SHIFT  = DECAY_SHIFT_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [NLEDS-1:0] i_led,
    output logic [NLEDS-1:0] o_pwm
);

    localparam int PRE_W = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
    localparam logic [PRE_W-1:0]    PRE_RELOAD = PRE_W'(DECAY_PERIOD - 1);
    localparam logic [PRE_W-1:0]    PRE_ONE    = PRE_W'(1);
    localparam logic [PWM_BITS-1:0] FULL       = '1;
    localparam logic [PWM_BITS-1:0] CTR_ONE    = PWM_BITS'(1);

    logic [PWM_BITS-1:0] pwm_ctr_q, pwm_ctr_d;
    logic [PRE_W-1:0]    prescaler_q, prescaler_d;
    logic                decay_tick;
    logic                period_end;

    always_comb begin
        decay_tick  = (prescaler_q == '0);
        period_end  = (pwm_ctr_q == FULL);
        pwm_ctr_d   = pwm_ctr_q + CTR_ONE;
        prescaler_d = decay_tick ? PRE_RELOAD : (prescaler_q - PRE_ONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pwm_ctr_q   <= '0;
            prescaler_q <= PRE_RELOAD;
        end else begin
            pwm_ctr_q   <= pwm_ctr_d;
            prescaler_q <= prescaler_d;
        end
    end

    for (genvar k = 0; k < NLEDS; k++) begin : g_ch
        led_fader_channel #(
            .PWM_BITS    (PWM_BITS),
            .DECAY_SHIFT (DECAY_SHIFT)
        ) u_ch (
            .i_clk        (i_clk),
            .i_reset      (i_reset),
            .i_sel        (i_led[k]),
            .i_decay_tick (decay_tick),
            .i_period_end (period_end),
            .i_pwm_ctr    (pwm_ctr_q),
            .o_pwm        (o_pwm[k])
        );
    end

endmodule
